// File: rtl/ahb_pkg.sv
// AHB 2.0 transfer, burst and response encodings shared by the arbiter and the masters.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  localparam int BEAT_W = 4;

  // Beats still owed after the NONSEQ of a protected burst; wrapping bursts are arbitrated like INCR.
  function automatic logic [BEAT_W-1:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      HBURST_INCR4:  burst_beats = 4'd3;
      HBURST_INCR8:  burst_beats = 4'd7;
      HBURST_INCR16: burst_beats = 4'd15;
      default:       burst_beats = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: first requester strictly after `last`, wrapping.
module ahb_rr_pick #(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [MW-1:0]          last,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [MW-1:0]          idx,
  output logic                   valid
);

  logic [MW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      cand = MW'((int'(last) + off) % NUM_MASTERS);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB 2.0 arbiter with fixed-burst and lock protection and SPLIT masking.
// Drives the address/data mux selects through o_hmaster and o_hmaster_d.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = $clog2(NUM_MASTERS)
) (
  input  logic                   i_hclk,
  input  logic                   i_hreset_n,
  input  logic [NUM_MASTERS-1:0] i_hbusreq,
  input  logic [NUM_MASTERS-1:0] i_hlock,
  input  logic [1:0]             i_htrans,
  input  logic [2:0]             i_hburst,
  input  logic                   i_hready,
  input  logic [1:0]             i_hresp,
  input  logic [NUM_MASTERS-1:0] i_hsplit,
  output logic [NUM_MASTERS-1:0] o_hgrant,
  output logic [MW-1:0]          o_hmaster,
  output logic [MW-1:0]          o_hmaster_d,
  output logic                   o_hmastlock,
  output logic                   o_park
);

  localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GNT = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

  logic [NUM_MASTERS-1:0] split_mask;
  logic [NUM_MASTERS-1:0] split_set;
  logic [NUM_MASTERS-1:0] excl;
  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [MW-1:0]          pick_idx;
  logic                   pick_valid;
  // Index of the granted master; it doubles as the round-robin pointer because
  // `last` only moves when the grant moves to a different master.
  logic [MW-1:0]          gnt_idx;
  logic [BEAT_W-1:0]      beats_left;

  logic                   resp_end;
  logic                   fixed_start;
  logic                   hold;
  logic [NUM_MASTERS-1:0] next_gnt;
  logic [MW-1:0]          next_idx;
  logic                   next_park;

  always_comb begin
    resp_end  = i_hready && (i_hresp == HRESP_SPLIT || i_hresp == HRESP_RETRY);
    excl      = '0;
    split_set = '0;
    if (resp_end)
      excl[o_hmaster_d] = 1'b1;
    if (i_hresp == HRESP_SPLIT && !i_hready)
      split_set[o_hmaster_d] = 1'b1;
    eligible = i_hbusreq & ~split_mask & ~excl;

    // The counter loads on the NONSEQ edge itself, so that edge must already hold the grant.
    fixed_start = (i_htrans == HTRANS_NONSEQ) && (burst_beats(i_hburst) != '0);
    hold = (i_hresp == HRESP_OKAY) &&
           ((beats_left > 4'd1) || fixed_start || (!o_park && i_hlock[gnt_idx]));

    if (pick_valid) begin
      next_gnt  = pick_gnt;
      next_idx  = pick_idx;
      next_park = 1'b0;
    end else if (!split_mask[DEFAULT_MASTER]) begin
      next_gnt  = DEF_GNT;
      next_idx  = DEF_IDX;
      next_park = 1'b0;
    end else begin
      next_gnt  = '0;
      next_idx  = gnt_idx;
      next_park = 1'b1;
    end
  end

  ahb_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .MW          (MW)
  ) u_pick (
    .req   (eligible),
    .last  (gnt_idx),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      o_hgrant    <= DEF_GNT;
      gnt_idx     <= DEF_IDX;
      o_park      <= 1'b0;
      o_hmaster   <= DEF_IDX;
      o_hmaster_d <= DEF_IDX;
      o_hmastlock <= 1'b0;
      split_mask  <= '0;
      beats_left  <= '0;
    end else begin
      // Release wins over a same-cycle SPLIT on the same master.
      split_mask <= (split_mask | split_set) & ~i_hsplit;

      if (i_hresp != HRESP_OKAY)
        beats_left <= '0;
      else if (i_hready) begin
        case (i_htrans)
          HTRANS_NONSEQ: beats_left <= burst_beats(i_hburst);
          HTRANS_SEQ:    if (beats_left != '0) beats_left <= beats_left - 4'd1;
          default:       ;
        endcase
      end

      if (i_hready) begin
        if (!hold) begin
          o_hgrant <= next_gnt;
          gnt_idx  <= next_idx;
          o_park   <= next_park;
        end
        if (!o_park)
          o_hmaster <= gnt_idx;
        o_hmastlock <= !o_park && i_hlock[gnt_idx];
        o_hmaster_d <= o_hmaster;
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed scenarios plus randomized traffic against a cycle-level reference model of the arbiter rules.
module tb_ahb_arbiter;
  import ahb_pkg::*;

  localparam int N   = 4;
  localparam int DEF = 0;
  localparam int MW  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  busreq = '0;
  logic [N-1:0]  hlock = '0;
  logic [1:0]    htrans = HTRANS_IDLE;
  logic [2:0]    hburst = HBURST_SINGLE;
  logic          hready = 1'b1;
  logic [1:0]    hresp = HRESP_OKAY;
  logic [N-1:0]  hsplit = '0;
  logic [N-1:0]  o_hgrant;
  logic [MW-1:0] o_hmaster;
  logic [MW-1:0] o_hmaster_d;
  logic          o_hmastlock;
  logic          o_park;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF), .MW(MW)) dut (
    .i_hclk      (clk),
    .i_hreset_n  (rst_n),
    .i_hbusreq   (busreq),
    .i_hlock     (hlock),
    .i_htrans    (htrans),
    .i_hburst    (hburst),
    .i_hready    (hready),
    .i_hresp     (hresp),
    .i_hsplit    (hsplit),
    .o_hgrant    (o_hgrant),
    .o_hmaster   (o_hmaster),
    .o_hmaster_d (o_hmaster_d),
    .o_hmastlock (o_hmastlock),
    .o_park      (o_park)
  );

  // Reference model state, plain integers.
  int     m_gnt, m_last, m_master, m_master_d, m_beats;
  bit     m_park, m_lock;
  bit [N-1:0] m_split;

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] one;
    one = 4'b0001;
    return m_park ? 4'b0000 : (one << m_gnt);
  endfunction

  task automatic model_reset();
    m_gnt = DEF; m_last = DEF; m_master = DEF; m_master_d = DEF;
    m_beats = 0; m_park = 0; m_lock = 0; m_split = '0;
  endtask

  task automatic model_step();
    int o_gnt, o_master, win, c;
    bit o_park, held, fixed, resp_end;
    bit [N-1:0] o_split;
    o_gnt = m_gnt; o_master = m_master; o_park = m_park; o_split = m_split;
    fixed = (htrans == HTRANS_NONSEQ) &&
            (hburst == HBURST_INCR4 || hburst == HBURST_INCR8 || hburst == HBURST_INCR16);
    resp_end = hready && (hresp == HRESP_SPLIT || hresp == HRESP_RETRY);
    held = (hresp == HRESP_OKAY) && (m_beats > 1 || fixed || (!o_park && hlock[o_gnt]));
    if (hready && !held) begin
      win = -1;
      for (int off = 1; off <= N; off++) begin
        c = (m_last + off) % N;
        if (win < 0 && busreq[c] && !o_split[c] && !(resp_end && c == m_master_d)) win = c;
      end
      if (win < 0 && !o_split[DEF]) win = DEF;
      if (win < 0) m_park = 1;
      else begin m_park = 0; m_gnt = win; m_last = win; end
    end
    if (hresp != HRESP_OKAY) m_beats = 0;
    else if (hready) begin
      if (htrans == HTRANS_NONSEQ)
        m_beats = (hburst == HBURST_INCR4) ? 3 : (hburst == HBURST_INCR8) ? 7 :
                  (hburst == HBURST_INCR16) ? 15 : 0;
      else if (htrans == HTRANS_SEQ && m_beats > 0) m_beats--;
    end
    for (int m = 0; m < N; m++) begin
      if (hsplit[m]) m_split[m] = 0;
      else if (hresp == HRESP_SPLIT && !hready && m == m_master_d) m_split[m] = 1;
    end
    if (hready) begin
      m_lock = !o_park && hlock[o_gnt];
      m_master_d = o_master;
      if (!o_park) m_master = o_gnt;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; busreq = '0; hlock = '0; htrans = HTRANS_IDLE; hburst = HBURST_SINGLE;
    hready = 1; hresp = HRESP_OKAY; hsplit = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (o_hgrant !== 4'b0001) begin errors++; $display("FAIL reset_grant: got %b want 0001", o_hgrant); end
    if (o_hmaster !== 2'd0) begin errors++; $display("FAIL reset_hmaster: got %0d want 0", o_hmaster); end
    if (o_hmaster_d !== 2'd0) begin errors++; $display("FAIL reset_hmaster_d: got %0d want 0", o_hmaster_d); end
    if (o_hmastlock !== 1'b0) begin errors++; $display("FAIL reset_mastlock: got %b want 0", o_hmastlock); end
    if (o_park !== 1'b0) begin errors++; $display("FAIL reset_park: got %b want 0", o_park); end
  endtask

  task automatic test_round_robin();
    int e, h1, h2;
    do_reset();
    busreq = 4'b0110; htrans = HTRANS_NONSEQ; hburst = HBURST_SINGLE;
    h1 = 0; h2 = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      e = (k % 2 == 0) ? 1 : 2;
      checks += 3;
      if (o_hgrant !== 4'(1 << e)) begin errors++; $display("FAIL rr_grant k=%0d: got %b want %b", k, o_hgrant, 4'(1 << e)); end
      if (o_hmaster !== 2'(h1)) begin errors++; $display("FAIL rr_hmaster k=%0d: got %0d want %0d", k, o_hmaster, h1); end
      if (o_hmaster_d !== 2'(h2)) begin errors++; $display("FAIL rr_hmaster_d k=%0d: got %0d want %0d", k, o_hmaster_d, h2); end
      h2 = h1; h1 = e;
    end
  endtask

  task automatic test_burst_hold();
    logic [1:0] tseq [9];
    logic [N-1:0] e;
    tseq = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_BUSY,
             HTRANS_SEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_SEQ};
    do_reset();
    busreq = 4'b0010; htrans = HTRANS_IDLE;
    tick(); tick();
    checks++;
    if (o_hmaster !== 2'd1) begin errors++; $display("FAIL burst_owner: got %0d want 1", o_hmaster); end
    busreq = 4'b1010; hburst = HBURST_INCR8;
    for (int i = 0; i < 9; i++) begin
      htrans = tseq[i];
      tick();
      e = (i < 8) ? 4'b0010 : 4'b1000;
      checks += 2;
      if (o_hgrant !== e) begin errors++; $display("FAIL burst_grant beat=%0d: got %b want %b", i, o_hgrant, e); end
      if (o_hgrant !== exp_gnt()) begin errors++; $display("FAIL burst_model beat=%0d: got %b want %b", i, o_hgrant, exp_gnt()); end
    end
    htrans = HTRANS_IDLE;
    checks++;
    if (o_hmaster !== 2'd1) begin errors++; $display("FAIL burst_handover_a: got %0d want 1", o_hmaster); end
    tick();
    checks++;
    if (o_hmaster !== 2'd3) begin errors++; $display("FAIL burst_handover_b: got %0d want 3", o_hmaster); end
  endtask

  task automatic test_lock();
    do_reset();
    busreq = 4'b0100; hlock = 4'b0100; htrans = HTRANS_IDLE;
    tick();
    checks++;
    if (o_hgrant !== 4'b0100) begin errors++; $display("FAIL lock_first_grant: got %b want 0100", o_hgrant); end
    busreq = 4'b0101; htrans = HTRANS_NONSEQ; hburst = HBURST_SINGLE;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks += 2;
      if (o_hgrant !== 4'b0100) begin errors++; $display("FAIL lock_hold i=%0d: got %b want 0100", i, o_hgrant); end
      if (o_hmastlock !== 1'b1) begin errors++; $display("FAIL lock_mastlock i=%0d: got %b want 1", i, o_hmastlock); end
    end
    hlock = '0; busreq = 4'b0001; htrans = HTRANS_IDLE;
    tick();
    checks++;
    if (o_hgrant !== 4'b0001) begin errors++; $display("FAIL lock_release: got %b want 0001", o_hgrant); end
  endtask

  task automatic test_split();
    do_reset();
    busreq = 4'b0010; htrans = HTRANS_NONSEQ; hburst = HBURST_SINGLE;
    tick(); tick(); tick();
    checks++;
    if (o_hmaster_d !== 2'd1) begin errors++; $display("FAIL split_dataphase: got %0d want 1", o_hmaster_d); end
    htrans = HTRANS_IDLE; hresp = HRESP_SPLIT; hready = 0;
    tick();
    checks++;
    if (o_hgrant !== 4'b0010) begin errors++; $display("FAIL split_frozen: got %b want 0010", o_hgrant); end
    hready = 1;
    tick();
    checks++;
    if (o_hgrant !== 4'b0001) begin errors++; $display("FAIL split_regrant: got %b want 0001", o_hgrant); end
    hresp = HRESP_OKAY; busreq = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (o_hgrant !== 4'b1000) begin errors++; $display("FAIL split_masked i=%0d: got %b want 1000", i, o_hgrant); end
    end
    hsplit = 4'b0010; busreq = 4'b0010;
    tick();
    hsplit = '0;
    tick();
    checks++;
    if (o_hgrant !== 4'b0010) begin errors++; $display("FAIL split_release: got %b want 0010", o_hgrant); end
  endtask

  task automatic test_park();
    int w;
    do_reset();
    htrans = HTRANS_NONSEQ; hburst = HBURST_SINGLE;
    for (int m = 0; m < N; m++) begin
      busreq = 4'(1 << m);
      w = 0;
      while (m_master_d != m && w < 8) begin tick(); w++; end
      checks++;
      if (o_hmaster_d !== 2'(m)) begin errors++; $display("FAIL park_reach m=%0d: got %0d want %0d", m, o_hmaster_d, m); end
      hresp = HRESP_SPLIT; hready = 0;
      tick();
      hready = 1;
      tick();
      hresp = HRESP_OKAY;
    end
    checks += 2;
    if (o_park !== 1'b1) begin errors++; $display("FAIL park_on: got %b want 1", o_park); end
    if (o_hgrant !== 4'b0000) begin errors++; $display("FAIL park_grant: got %b want 0000", o_hgrant); end
    busreq = '0; hsplit = 4'b0001;
    tick();
    hsplit = '0;
    tick();
    checks += 2;
    if (o_park !== 1'b0) begin errors++; $display("FAIL park_off: got %b want 0", o_park); end
    if (o_hgrant !== 4'b0001) begin errors++; $display("FAIL park_default: got %b want 0001", o_hgrant); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    busreq = 4'b0010; htrans = HTRANS_IDLE;
    tick(); tick();
    busreq = 4'b1010; htrans = HTRANS_NONSEQ; hburst = HBURST_INCR16;
    tick();
    htrans = HTRANS_SEQ;
    tick(); tick();
    hready = 0;
    tick();
    checks++;
    if (o_hgrant !== 4'b0010) begin errors++; $display("FAIL midrst_pre: got %b want 0010", o_hgrant); end
    #2 rst_n = 0;
    #1;
    checks += 4;
    if (o_hgrant !== 4'b0001) begin errors++; $display("FAIL midrst_grant: got %b want 0001", o_hgrant); end
    if (o_hmaster !== 2'd0) begin errors++; $display("FAIL midrst_hmaster: got %0d want 0", o_hmaster); end
    if (o_hmaster_d !== 2'd0) begin errors++; $display("FAIL midrst_hmaster_d: got %0d want 0", o_hmaster_d); end
    if (o_park !== 1'b0 || o_hmastlock !== 1'b0) begin errors++; $display("FAIL midrst_flags: got park=%b lock=%b want 0 0", o_park, o_hmastlock); end
    model_reset();
    hready = 1; busreq = 4'b1000; htrans = HTRANS_SEQ;
    @(negedge clk);
    rst_n = 1;
    tick();
    checks++;
    if (o_hgrant !== 4'b1000) begin errors++; $display("FAIL midrst_no_hold: got %b want 1000", o_hgrant); end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      busreq = 4'($urandom);
      hlock  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      htrans = 2'($urandom);
      hburst = 3'($urandom);
      hready = ($urandom_range(0, 4) != 0);
      hresp  = ($urandom_range(0, 5) == 0) ? 2'($urandom) : HRESP_OKAY;
      hsplit = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      tick();
      checks += 5;
      if (o_hgrant !== exp_gnt()) begin errors++; $display("FAIL rnd_grant k=%0d: got %b want %b", k, o_hgrant, exp_gnt()); end
      if (o_park !== m_park) begin errors++; $display("FAIL rnd_park k=%0d: got %b want %b", k, o_park, m_park); end
      if (o_hmaster !== 2'(m_master)) begin errors++; $display("FAIL rnd_hmaster k=%0d: got %0d want %0d", k, o_hmaster, m_master); end
      if (o_hmaster_d !== 2'(m_master_d)) begin errors++; $display("FAIL rnd_hmaster_d k=%0d: got %0d want %0d", k, o_hmaster_d, m_master_d); end
      if (o_hmastlock !== m_lock) begin errors++; $display("FAIL rnd_mastlock k=%0d: got %b want %b", k, o_hmastlock, m_lock); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_burst_hold();
    test_lock();
    test_split();
    test_park();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
